// File: rtl/bvh_fetch_arbiter_pkg.sv
// bvh_fetch_arbiter_pkg: shared widths and types for the BVH fetch arbiter.
package bvh_fetch_arbiter_pkg;
    localparam int BVH_PRIMITIVE_INDEX_WIDTH  = 16;
    localparam int BVH_PRIMITIVE_AMOUNT_WIDTH = 8;
    localparam int BVH_FETCH_ID_WIDTH         = 4;

    typedef enum logic {BFK_Node = 1'b0, BFK_Primitive = 1'b1} BVHFetchKind;
    typedef enum logic {BFS_Idle = 1'b0, BFS_Burst = 1'b1} BVHFetchState;

    typedef struct packed {
        logic                          Valid;
        logic [BVH_FETCH_ID_WIDTH-1:0] Id;
        logic                          Last;
    } BVHFetchTag;
endpackage

// File: rtl/bvh_rr_picker.sv
// bvh_rr_picker: combinational round-robin picker, searching upward from rr_i with wrap.
module bvh_rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[(int'(rr_i) + k) % N]) begin
                any_o = 1'b1;
                idx_o = IW'((int'(rr_i) + k) % N);
            end
        end
        gnt_o[idx_o] = any_o;
    end
endmodule

// File: rtl/bvh_fetch_arbiter.sv
// bvh_fetch_arbiter: round-robin sharing of one fixed-latency BVH read port among burst requesters.
module bvh_fetch_arbiter
    import bvh_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int AW          = BVH_PRIMITIVE_INDEX_WIDTH,
    parameter int CW          = BVH_PRIMITIVE_AMOUNT_WIDTH,
    parameter int DW          = 512,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_kind,
    input  logic [NUM_REQ*AW-1:0] req_start,
    input  logic [NUM_REQ*CW-1:0] req_count,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_last,
    output logic [DW-1:0]         rsp_data,
    output logic                  mem_rd_en,
    output logic                  mem_rd_kind,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [DW-1:0]         mem_rd_data,
    output logic                  busy
);
    localparam int IW = $clog2(NUM_REQ);

    BVHFetchState       state_q, state_d;
    BVHFetchKind        cur_kind_q, cur_kind_d;
    logic [IW-1:0]      rr_q, rr_d, cur_id_q, cur_id_d;
    logic [AW-1:0]      cur_addr_q, cur_addr_d;
    logic [CW-1:0]      rem_q, rem_d;
    logic [NUM_REQ-1:0] ack_q, ack_d, zdone_q, zdone_d;
    BVHFetchTag         tag_q [MEM_LATENCY];
    BVHFetchTag         push, out_tag;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      idx;
    logic               any, inflight;

    // The requester just acked still holds req_valid for one more cycle; mask it out.
    bvh_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .req_i(req_valid & ~ack_q),
        .rr_i (rr_q),
        .gnt_o(gnt),
        .idx_o(idx),
        .any_o(any)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cur_id_d   = cur_id_q;
        cur_kind_d = cur_kind_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        ack_d      = '0;
        zdone_d    = '0;
        if (state_q == BFS_Idle) begin
            if (any) begin
                cur_id_d   = idx;
                cur_kind_d = BVHFetchKind'(req_kind[idx]);
                cur_addr_d = req_start[idx*AW +: AW];
                rem_d      = req_count[idx*CW +: CW];
                rr_d       = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
                ack_d      = gnt;
                zdone_d    = (rem_d == '0) ? gnt : '0;
                state_d    = (rem_d == '0) ? BFS_Idle : BFS_Burst;
            end
        end else begin
            cur_addr_d = cur_addr_q + AW'(1);
            rem_d      = rem_q - CW'(1);
            state_d    = (rem_q == CW'(1)) ? BFS_Idle : BFS_Burst;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= BFS_Idle;
            rr_q       <= '0;
            cur_id_q   <= '0;
            cur_kind_q <= BFK_Node;
            cur_addr_q <= '0;
            rem_q      <= '0;
            ack_q      <= '0;
            zdone_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cur_id_q   <= cur_id_d;
            cur_kind_q <= cur_kind_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            ack_q      <= ack_d;
            zdone_q    <= zdone_d;
        end
    end

    assign push = '{Valid: mem_rd_en, Id: BVH_FETCH_ID_WIDTH'(cur_id_q), Last: rem_q == CW'(1)};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MEM_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= push;
            for (int i = 1; i < MEM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight | tag_q[i].Valid;
    end

    assign out_tag     = tag_q[MEM_LATENCY-1];
    assign mem_rd_en   = (state_q == BFS_Burst);
    assign mem_rd_kind = mem_rd_en & (cur_kind_q == BFK_Primitive);
    assign mem_rd_addr = cur_addr_q;
    assign rsp_valid   = out_tag.Valid ? (NUM_REQ'(1) << out_tag.Id) : '0;
    assign rsp_last    = out_tag.Valid & out_tag.Last;
    assign rsp_data    = mem_rd_data;
    assign req_ack     = ack_q;
    assign req_done    = (rsp_valid & {NUM_REQ{rsp_last}}) | zdone_q;
    assign busy        = (state_q != BFS_Idle) | inflight;
endmodule
